// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts word read requests into a small FIFO,
// serves them in order from a preloadable synchronous-read memory after a
// fixed wait, and holds each response until the consumer takes it.
// Optional feature: define IMEM_RANGE_CHECK_EN to flag requests whose address
// lies beyond the memory (resp_err=1, resp_data=0); without it the upper
// address bits are ignored and resp_err stays 0.
module inst_mem_responder #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_BYTE_WIDTH  = 3,
    parameter int unsigned MEM_DEPTH_WIDTH  = 10,
    parameter int unsigned LATENCY          = 2,
    parameter int unsigned FIFO_DEPTH_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_busy,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    output logic                                 resp_valid,
    input  logic                                 resp_busy,
    output logic [(8 << DATA_BYTE_WIDTH)-1:0]    resp_data,
    input  logic                                 init_we,
    input  logic [MEM_DEPTH_WIDTH-1:0]           init_addr,
    input  logic [(8 << DATA_BYTE_WIDTH)-1:0]    init_data,
    output logic                                 resp_err
);

    localparam int unsigned DW         = 8 << DATA_BYTE_WIDTH;
    localparam int unsigned MEM_DEPTH  = 1 << MEM_DEPTH_WIDTH;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_WIDTH;
    localparam int unsigned CW         = FIFO_DEPTH_WIDTH + 1;
    localparam int unsigned PW         = FIFO_DEPTH_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    logic [DW-1:0]              mem      [MEM_DEPTH];
    logic [MEM_DEPTH_WIDTH-1:0] fifo_idx [FIFO_DEPTH];
    logic                       fifo_err [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    state_t                     state;
    logic [3:0]                 wait_cnt;
    logic [MEM_DEPTH_WIDTH-1:0] addr_idx;
    logic                       addr_err;

    logic [MEM_DEPTH_WIDTH-1:0] req_idx_c;
    logic                       req_err_c;
    logic                       push_c;
    logic                       pop_c;
    logic                       fifo_empty_c;
    logic                       resp_xfer_c;
    logic                       unused_addr;

    // Handshake decode: push on accepted request, pop when the FSM can start a read.
    assign req_busy     = (count == CW'(FIFO_DEPTH));
    assign fifo_empty_c = (count == '0);
    assign push_c       = req_valid && !req_busy;
    assign resp_xfer_c  = resp_valid && !resp_busy;
    assign pop_c        = !fifo_empty_c &&
                          ((state == IDLE) || ((state == SEND) && resp_xfer_c));
    assign req_idx_c    = req_addr[DATA_BYTE_WIDTH +: MEM_DEPTH_WIDTH];
    assign unused_addr  = ^req_addr;

`ifdef IMEM_RANGE_CHECK_EN
    localparam int unsigned HI_LSB = DATA_BYTE_WIDTH + MEM_DEPTH_WIDTH;
    // Any set bit above the memory window marks the request out of range.
    assign req_err_c = ((req_addr >> HI_LSB) != '0);
`else
    assign req_err_c = 1'b0;
`endif

    // Preload port: memory is never reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
    end

    // Request FIFO storage.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_idx[wr_ptr] <= req_idx_c;
            fifo_err[wr_ptr] <= req_err_c;
        end
    end

    // Request FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Read FSM: pop a request, wait LATENCY cycles, present the word until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_idx   <= '0;
            addr_err   <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        addr_idx <= fifo_idx[rd_ptr];
                        addr_err <= fifo_err[rd_ptr];
                        wait_cnt <= 4'(LATENCY);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_data  <= addr_err ? '0 : mem[addr_idx];
                        resp_err   <= addr_err;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (resp_xfer_c) begin
                        resp_valid <= 1'b0;
                        if (pop_c) begin
                            addr_idx <= fifo_idx[rd_ptr];
                            addr_err <= fifo_err[rd_ptr];
                            wait_cnt <= 4'(LATENCY);
                            state    <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
